// File: rtl/axis_beam_cmult_if.sv
// AXI-Stream style complex-sample bus shared by the beamformer input and output.
// Parameters: DATA_W - width of each of the real/imag data buses
//             KEEP_W - byte-enable width (DATA_W/8)
// Signals:    tvalid/tready handshake, tlast frame end, tdata_real/tdata_imag
//             sample data, tkeep byte enables (driven by the master side only).
interface axis_beam_cmult_if #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned KEEP_W = DATA_W / 8
);
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [DATA_W-1:0] tdata_real;
   logic [DATA_W-1:0] tdata_imag;
   logic [KEEP_W-1:0] tkeep;

   modport master (output tvalid, tlast, tdata_real, tdata_imag, tkeep, input tready);
   modport slave  (input tvalid, tlast, tdata_real, tdata_imag, output tready);
endinterface

// File: rtl/axis_beam_cmult.sv
// Per-channel complex weight multiplier for a multi-lane antenna stream.
// Every sample of channel c is multiplied by channel c's active weight,
// rounded half-up, shifted by FRAC_W and narrowed to SAMPLE_W bits.
// Weights are written to a shadow bank and copied to the active bank only
// between frames, so a frame never sees a weight change mid-way.
//
// Ports:
//   clock, resetn        - rising-edge clock, synchronous active-low reset
//   w_valid/w_ch         - write shadow weight (w_real, w_imag) of channel w_ch
//   w_commit             - request a shadow-to-active copy at the next frame gap
//   s_axis (slave)       - input stream, tready = !m.tvalid | m.tready
//   m_axis (master)      - weighted output stream, 3-stage latency
//   sat_flag             - sticky clamp indicator
//
// Build option: define AXIS_BEAM_CMULT_SAT_EN to saturate on narrowing
// (and drive sat_flag); otherwise results wrap and sat_flag is tied low.
module axis_beam_cmult #(
   parameter int unsigned NCH      = 4,
   parameter int unsigned LANES    = 8,
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned WEIGHT_W = 8,
   parameter int unsigned FRAC_W   = 6,
   localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       w_valid,
   input  logic [CH_W-1:0]            w_ch,
   input  logic signed [WEIGHT_W-1:0] w_real,
   input  logic signed [WEIGHT_W-1:0] w_imag,
   input  logic                       w_commit,
   axis_beam_cmult_if.slave           s_axis,
   axis_beam_cmult_if.master          m_axis,
   output logic                       sat_flag
);

   localparam int unsigned NS = NCH * LANES;
   localparam int unsigned DW = NS * SAMPLE_W;
   localparam int unsigned PW = SAMPLE_W + WEIGHT_W;
   localparam int unsigned SW = PW + 1;
   localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(32'd1 << FRAC_W);
   localparam logic signed [SW-1:0]       RND   = SW'(32'd1 << (FRAC_W - 1));

   typedef enum logic {IDLE, FRAME} state_t;

   state_t state;
   logic   pending;
   logic   adv;
   logic   accept;
   logic   copy_en;

   logic signed [WEIGHT_W-1:0] shd_re [NCH];
   logic signed [WEIGHT_W-1:0] shd_im [NCH];
   logic signed [WEIGHT_W-1:0] act_re [NCH];
   logic signed [WEIGHT_W-1:0] act_im [NCH];
   logic signed [WEIGHT_W-1:0] s1_wr  [NCH];
   logic signed [WEIGHT_W-1:0] s1_wi  [NCH];

   logic [DW-1:0] s1_xr;
   logic [DW-1:0] s1_xi;
   logic [DW-1:0] nar_re;
   logic [DW-1:0] nar_im;
   logic          s1_valid;
   logic          s1_last;
   logic          s2_valid;
   logic          s2_last;

   // Whole pipeline moves in lock-step whenever the output slot can be refilled.
   assign adv           = !m_axis.tvalid || m_axis.tready;
   assign s_axis.tready = adv;
   assign accept        = s_axis.tvalid && adv;

   // Copy when idle with no beat arriving, or on the edge that accepts a frame's
   // last beat; that beat still captures the old active bank.
   assign copy_en = (pending || w_commit) && (accept ? s_axis.tlast : (state == IDLE));

   // Frame tracker and commit-pending flag.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= IDLE;
         pending <= 1'b0;
      end else begin
         if (accept) state <= s_axis.tlast ? IDLE : FRAME;
         if (copy_en)       pending <= 1'b0;
         else if (w_commit) pending <= 1'b1;
      end
   end

   // Shadow/active weight banks; a same-cycle shadow write lands after the copy.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         for (int c = 0; c < NCH; c++) begin
            shd_re[c] <= W_ONE;
            shd_im[c] <= '0;
            act_re[c] <= W_ONE;
            act_im[c] <= '0;
         end
      end else begin
         if (w_valid) begin
            shd_re[w_ch] <= w_real;
            shd_im[w_ch] <= w_imag;
         end
         if (copy_en) begin
            act_re <= shd_re;
            act_im <= shd_im;
         end
      end
   end

   // Stage valid/last chain.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
      end else if (adv) begin
         s1_valid <= accept;
         s1_last  <= s_axis.tlast;
         s2_valid <= s1_valid;
         s2_last  <= s1_last;
      end
   end

   // Stage 1: sample and weight capture travel together.
   always_ff @(posedge clock) begin
      if (adv) begin
         s1_xr <= s_axis.tdata_real;
         s1_xi <= s_axis.tdata_imag;
         s1_wr <= act_re;
         s1_wi <= act_im;
      end
   end

`ifdef AXIS_BEAM_CMULT_SAT_EN
   localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
   logic [NS-1:0] clamp;
`endif

   for (genvar i = 0; i < NS; i++) begin : g_smp
      localparam int unsigned C = i / LANES;

      logic signed [SAMPLE_W-1:0] xr;
      logic signed [SAMPLE_W-1:0] xi;
      logic signed [PW-1:0]       p_rr;
      logic signed [PW-1:0]       p_ii;
      logic signed [PW-1:0]       p_ri;
      logic signed [PW-1:0]       p_ir;
      logic signed [SW-1:0]       sum_re;
      logic signed [SW-1:0]       sum_im;

      assign xr = s1_xr[i*SAMPLE_W +: SAMPLE_W];
      assign xi = s1_xi[i*SAMPLE_W +: SAMPLE_W];

      // Stage 2: the four partial products.
      always_ff @(posedge clock) begin
         if (adv) begin
            p_rr <= PW'(xr) * PW'(s1_wr[C]);
            p_ii <= PW'(xi) * PW'(s1_wi[C]);
            p_ri <= PW'(xr) * PW'(s1_wi[C]);
            p_ir <= PW'(xi) * PW'(s1_wr[C]);
         end
      end

      // Stage 3 (combinational part): full-precision sum with half-LSB rounding.
      assign sum_re = SW'(p_rr) - SW'(p_ii) + RND;
      assign sum_im = SW'(p_ri) + SW'(p_ir) + RND;

`ifdef AXIS_BEAM_CMULT_SAT_EN
      logic signed [SW-1:0] sh_re;
      logic signed [SW-1:0] sh_im;
      logic                 ovf_re;
      logic                 ovf_im;

      assign sh_re  = sum_re >>> FRAC_W;
      assign sh_im  = sum_im >>> FRAC_W;
      // Out of range when the bits above the target sign bit are not all sign copies.
      assign ovf_re = sh_re[SW-1:SAMPLE_W-1] != {(SW-SAMPLE_W+1){sh_re[SW-1]}};
      assign ovf_im = sh_im[SW-1:SAMPLE_W-1] != {(SW-SAMPLE_W+1){sh_im[SW-1]}};
      assign nar_re[i*SAMPLE_W +: SAMPLE_W] =
         ovf_re ? (sh_re[SW-1] ? S_MIN : S_MAX) : sh_re[SAMPLE_W-1:0];
      assign nar_im[i*SAMPLE_W +: SAMPLE_W] =
         ovf_im ? (sh_im[SW-1] ? S_MIN : S_MAX) : sh_im[SAMPLE_W-1:0];
      assign clamp[i] = ovf_re || ovf_im;
`else
      assign nar_re[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(sum_re >>> FRAC_W);
      assign nar_im[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(sum_im >>> FRAC_W);
`endif
   end

   // Stage 3 register doubles as the output slot; it holds while stalled.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         m_axis.tvalid     <= 1'b0;
         m_axis.tlast      <= 1'b0;
         m_axis.tkeep      <= '0;
         m_axis.tdata_real <= '0;
         m_axis.tdata_imag <= '0;
      end else if (adv) begin
         m_axis.tvalid     <= s2_valid;
         m_axis.tlast      <= s2_last;
         m_axis.tkeep      <= s2_valid ? '1 : '0;
         m_axis.tdata_real <= nar_re;
         m_axis.tdata_imag <= nar_im;
      end
   end

`ifdef AXIS_BEAM_CMULT_SAT_EN
   // Sticky: any clamp on a beat entering the output slot.
   always_ff @(posedge clock) begin
      if (!resetn)                           sat_flag <= 1'b0;
      else if (adv && s2_valid && (|clamp))  sat_flag <= 1'b1;
   end
`else
   assign sat_flag = 1'b0;
`endif

endmodule
